// File: rtl/tmcspi_pkg.sv
// tmcspi scheduler shared types and datagram helpers.
// Datagram layout is {wr, addr[6:0], data[31:0]}.
package tmcspi_pkg;

  localparam int DGRAM_W = 40;
  localparam int ADDR_W  = 7;
  localparam int DATA_W  = 32;

  localparam int ST_HI = 39;
  localparam int ST_LO = 32;
  localparam int DT_HI = 31;
  localparam int DT_LO = 0;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    GAP,
    COMPLETE
  } state_t;

  // Reads always carry a zero payload.
  function automatic logic [DGRAM_W-1:0] mk_dgram(
    input logic              wr,
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] data
  );
    return {wr, addr, wr ? data : {DATA_W{1'b0}}};
  endfunction

endpackage

// File: rtl/tmcspi_sched_if.sv
// Host slot, poller outputs and SPI engine link of the scheduler.
// slave = scheduler side, master = host/engine side.
interface tmcspi_sched_if;
  import tmcspi_pkg::*;

  logic                host_req;
  logic                host_wr;
  logic [ADDR_W-1:0]   host_addr;
  logic [DATA_W-1:0]   host_wdata;
  logic                host_ack;
  logic [DATA_W-1:0]   host_rdata;
  logic [7:0]          host_status;
  logic                poll_en;
  logic                poll_valid;
  logic [DATA_W-1:0]   poll_data;
  logic [7:0]          poll_status;
  logic                spi_start;
  logic [DGRAM_W-1:0]  spi_tx;
  logic                spi_done;
  logic [DGRAM_W-1:0]  spi_rx;

  modport slave (
    input  host_req, host_wr, host_addr,
    input  host_wdata, poll_en,
    input  spi_done, spi_rx,
    output host_ack, host_rdata, host_status,
    output poll_valid, poll_data, poll_status,
    output spi_start, spi_tx
  );

  modport master (
    output host_req, host_wr, host_addr,
    output host_wdata, poll_en,
    output spi_done, spi_rx,
    input  host_ack, host_rdata, host_status,
    input  poll_valid, poll_data, poll_status,
    input  spi_start, spi_tx
  );

endinterface

// File: rtl/tmcspi_poll_timer.sv
// Poll period counter; raises poll_pend on terminal count.
// Terminal counts landing on a pending poll are dropped.
module tmcspi_poll_timer #(
  parameter int POLL_PERIOD = 1000
) (
  input  logic ACLK,
  input  logic ARESET,
  input  logic poll_en,
  input  logic clr_pend,
  output logic poll_pend
);

  localparam logic [15:0] TC = 16'(POLL_PERIOD - 1);

  logic [15:0] cnt;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      cnt       <= '0;
      poll_pend <= 1'b0;
    end else if (!poll_en) begin
      cnt       <= '0;
      poll_pend <= 1'b0;
    end else begin
      cnt <= (cnt == TC) ? 16'd0 : cnt + 16'd1;
      if (clr_pend)
        poll_pend <= 1'b0;
      else if (cnt == TC)
        poll_pend <= 1'b1;
    end
  end

endmodule

// File: rtl/tmcspi_sched.sv
// Shares the SPI datagram engine between host slot and poller.
// Reads issue two datagrams to absorb the TMC5130 read pipeline.
module tmcspi_sched
  import tmcspi_pkg::*;
#(
  parameter int                POLL_PERIOD = 1000,
  parameter logic [ADDR_W-1:0] POLL_ADDR   = 7'h6F,
  parameter int                GAP_CYCLES  = 4
) (
  input logic           ACLK,
  input logic           ARESET,
  tmcspi_sched_if.slave bus
);

  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

  state_t              state;
  logic                phase;
  logic                last_host;
  logic                cur_host;
  logic                cur_wr;
  logic [ADDR_W-1:0]   cur_addr;
  logic [DATA_W-1:0]   cur_wdata;
  logic [15:0]         gcnt;
  logic [DGRAM_W-1:0]  rx_q;
  logic                start_q;
  logic [DGRAM_W-1:0]  tx_q;
  logic                ack_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [7:0]          hstat_q;
  logic                pv_q;
  logic [DATA_W-1:0]   pdata_q;
  logic [7:0]          pstat_q;

  logic                poll_pend;
  logic                pick_host;
  logic                pick_poll;
  logic                g_wr;
  logic [ADDR_W-1:0]   g_addr;
  logic [DATA_W-1:0]   g_wdata;

  tmcspi_poll_timer #(
    .POLL_PERIOD (POLL_PERIOD)
  ) u_timer (
    .ACLK      (ACLK),
    .ARESET    (ARESET),
    .poll_en   (bus.poll_en),
    .clr_pend  (pick_poll),
    .poll_pend (poll_pend)
  );

  // On a tie the requester not served last wins.
  always_comb begin
    pick_host = 1'b0;
    pick_poll = 1'b0;
    if (state == IDLE) begin
      unique case (1'b1)
        bus.host_req && poll_pend: begin
          pick_host = !last_host;
          pick_poll = last_host;
        end
        bus.host_req && !poll_pend: pick_host = 1'b1;
        !bus.host_req && poll_pend: pick_poll = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    g_wr    = pick_host & bus.host_wr;
    g_addr  = pick_host ? bus.host_addr : POLL_ADDR;
    g_wdata = pick_host ? bus.host_wdata : '0;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state     <= IDLE;
      phase     <= 1'b0;
      last_host <= 1'b0;
      cur_host  <= 1'b0;
      cur_wr    <= 1'b0;
      cur_addr  <= '0;
      cur_wdata <= '0;
      gcnt      <= '0;
      rx_q      <= '0;
      start_q   <= 1'b0;
      tx_q      <= '0;
      ack_q     <= 1'b0;
      rdata_q   <= '0;
      hstat_q   <= '0;
      pv_q      <= 1'b0;
      pdata_q   <= '0;
      pstat_q   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_host || pick_poll) begin
            cur_host  <= pick_host;
            last_host <= pick_host;
            cur_wr    <= g_wr;
            cur_addr  <= g_addr;
            cur_wdata <= g_wdata;
            start_q   <= 1'b1;
            tx_q      <= mk_dgram(g_wr, g_addr, g_wdata);
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          start_q <= 1'b0;
          state   <= WAIT;
        end
        WAIT: begin
          if (bus.spi_done) begin
            rx_q  <= bus.spi_rx;
            gcnt  <= '0;
            state <= GAP;
          end
        end
        GAP: begin
          if (gcnt != GAP_LAST) begin
            gcnt <= gcnt + 16'd1;
          end else if (!cur_wr && !phase) begin
            // Second read datagram fetches the pipelined data.
            phase   <= 1'b1;
            start_q <= 1'b1;
            tx_q    <= mk_dgram(cur_wr, cur_addr, cur_wdata);
            state   <= ISSUE;
          end else begin
            state <= COMPLETE;
            if (cur_host) begin
              ack_q   <= 1'b1;
              rdata_q <= rx_q[DT_HI:DT_LO];
              hstat_q <= rx_q[ST_HI:ST_LO];
            end else begin
              pv_q    <= 1'b1;
              pdata_q <= rx_q[DT_HI:DT_LO];
              pstat_q <= rx_q[ST_HI:ST_LO];
            end
          end
        end
        COMPLETE: begin
          ack_q <= 1'b0;
          pv_q  <= 1'b0;
          phase <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.spi_start   = start_q;
  assign bus.spi_tx      = tx_q;
  assign bus.host_ack    = ack_q;
  assign bus.host_rdata  = rdata_q;
  assign bus.host_status = hstat_q;
  assign bus.poll_valid  = pv_q;
  assign bus.poll_data   = pdata_q;
  assign bus.poll_status = pstat_q;

endmodule

// File: tb/tb_tmcspi_sched.sv
// Directed bench for tmcspi_sched with an SPI engine model
// and scoreboard queues for datagrams and results.
module tb_tmcspi_sched;

  localparam int GAP = 4;
  localparam int PER = 100;
  localparam int LAT = 8;
  localparam logic [39:0] SMASK = 40'hFF_0000_0000;
  localparam logic [39:0] FMASK = 40'hFF_FFFF_FFFF;
  localparam logic [39:0] PTX   = 40'h6F_0000_0000;

  typedef struct {
    logic [39:0] m;
    logic [39:0] v;
  } exp_t;

  logic tb_ACLK;
  logic tb_ARESET;

  tmcspi_sched_if bus();

  tmcspi_sched #(
    .POLL_PERIOD (PER),
    .POLL_ADDR   (7'h6F),
    .GAP_CYCLES  (GAP)
  ) dut (
    .ACLK   (tb_ACLK),
    .ARESET (tb_ARESET),
    .bus    (bus)
  );

  logic [39:0] tx_q[$];
  logic [39:0] rsp_q[$];
  exp_t        exp_h[$];
  exp_t        exp_p[$];
  int          st_h[$];
  int          dn_h[$];

  int cyc   = 0;
  int total = 0;
  int pass  = 0;
  int nfail = 0;
  int n_ack = 0;
  int n_pv  = 0;
  int eng_cnt = 0;

  task automatic chk(input string tag,
                     input logic [39:0] obs,
                     input logic [39:0] exp);
    total++;
    assert (obs === exp) pass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // sel: 0 host_ack, 1 poll_valid, 2 spi_start
  task automatic wait_ev(input int sel, input int budget,
                         input string tag, output int at);
    int  k;
    logic hit;
    k   = 0;
    hit = 1'b0;
    at  = -1;
    while (!hit && k < budget) begin
      @(negedge tb_ACLK);
      k++;
      hit = (sel == 0) ? bus.host_ack :
            (sel == 1) ? bus.poll_valid : bus.spi_start;
    end
    if (hit) at = cyc;
    chk({tag, "_seen"}, 40'(hit), 40'd1);
  endtask

  function automatic exp_t mk_exp(input logic [39:0] m,
                                  input logic [39:0] v);
    exp_t e;
    e.m = m;
    e.v = v;
    return e;
  endfunction

  initial begin
    tb_ACLK = 1'b0;
    forever #5 tb_ACLK = ~tb_ACLK;
  end

  initial forever begin
    @(posedge tb_ACLK);
    cyc++;
  end

  // SPI engine model: fixed latency, responses from rsp_q.
  initial begin : engine
    bus.spi_done = 1'b0;
    bus.spi_rx   = '0;
    forever begin
      @(negedge tb_ACLK);
      bus.spi_done = 1'b0;
      if (tb_ARESET) begin
        eng_cnt = 0;
      end else begin
        if (eng_cnt > 0) begin
          eng_cnt--;
          if (eng_cnt == 0) begin
            bus.spi_rx = (rsp_q.size() != 0) ? rsp_q.pop_front() : 40'h0;
            bus.spi_done = 1'b1;
            dn_h.push_back(cyc);
          end
        end
        if (bus.spi_start) begin
          st_h.push_back(cyc);
          chk("start_expected", 40'(tx_q.size() != 0), 40'd1);
          if (tx_q.size() != 0)
            chk("spi_tx", bus.spi_tx, tx_q.pop_front());
          eng_cnt = LAT;
        end
      end
    end
  end

  initial begin : outmon
    exp_t e;
    forever begin
      @(negedge tb_ACLK);
      if (!tb_ARESET && bus.host_ack) begin
        n_ack++;
        chk("ack_expected", 40'(exp_h.size() != 0), 40'd1);
        if (exp_h.size() != 0) begin
          e = exp_h.pop_front();
          chk("host_rsp", {bus.host_status, bus.host_rdata} & e.m, e.v);
        end
      end
      if (!tb_ARESET && bus.poll_valid) begin
        n_pv++;
        chk("pv_expected", 40'(exp_p.size() != 0), 40'd1);
        if (exp_p.size() != 0) begin
          e = exp_p.pop_front();
          chk("poll_rsp", {bus.poll_status, bus.poll_data} & e.m, e.v);
        end
      end
    end
  end

  initial begin : main
    int c, at, a, b, e, n0, s0;
    tb_ARESET      = 1'b1;
    bus.host_req   = 1'b0;
    bus.host_wr    = 1'b0;
    bus.host_addr  = '0;
    bus.host_wdata = '0;
    bus.poll_en    = 1'b0;
    repeat (3) @(negedge tb_ACLK);
    chk("rst_pulses", 40'({bus.host_ack, bus.poll_valid, bus.spi_start}), 40'd0);
    chk("rst_host_out", 40'({bus.host_status, bus.host_rdata}), 40'd0);
    chk("rst_poll_out", 40'({bus.poll_status, bus.poll_data}), 40'd0);
    chk("rst_spi_tx", bus.spi_tx, 40'd0);
    tb_ARESET = 1'b0;
    repeat (2) @(negedge tb_ACLK);

    // host write
    b = st_h.size();
    tx_q.push_back(40'hA0_0000_1234);
    rsp_q.push_back(40'h05_0000_0000);
    exp_h.push_back(mk_exp(SMASK, 40'h05_0000_0000));
    c = cyc;
    bus.host_req = 1'b1;
    bus.host_wr = 1'b1;
    bus.host_addr = 7'h20;
    bus.host_wdata = 32'h0000_1234;
    wait_ev(2, 20, "wr_start", at);
    chk("wr_start_lat", 40'(at), 40'(c + 1));
    wait_ev(0, 50, "wr_ack", a);
    bus.host_req = 1'b0;
    chk("wr_ack_time", 40'(a), 40'(dn_h[b] + 1 + GAP));
    @(negedge tb_ACLK);
    chk("wr_ack_1cyc", 40'(bus.host_ack), 40'd0);
    chk("wr_nstart", 40'(st_h.size()), 40'(b + 1));

    // host read
    @(negedge tb_ACLK);
    b = st_h.size();
    tx_q.push_back(40'h21_0000_0000);
    tx_q.push_back(40'h21_0000_0000);
    rsp_q.push_back(40'h01_1111_1111);
    rsp_q.push_back(40'h09_DEAD_BEEF);
    exp_h.push_back(mk_exp(FMASK, 40'h09_DEAD_BEEF));
    bus.host_req = 1'b1;
    bus.host_wr = 1'b0;
    bus.host_addr = 7'h21;
    wait_ev(0, 80, "rd_ack", a);
    bus.host_req = 1'b0;
    chk("rd_nstart", 40'(st_h.size()), 40'(b + 2));
    if (st_h.size() >= b + 2) begin
      chk("rd_gap", 40'(st_h[b+1] - dn_h[b]), 40'(GAP + 1));
      chk("rd_ack_time", 40'(a), 40'(dn_h[b+1] + 1 + GAP));
    end

    // reset during WAIT of a read
    repeat (2) @(negedge tb_ACLK);
    tx_q.push_back(40'h22_0000_0000);
    tx_q.push_back(40'h22_0000_0000);
    exp_h.push_back(mk_exp(FMASK, 40'h0));
    bus.host_req = 1'b1;
    bus.host_addr = 7'h22;
    wait_ev(2, 20, "ab_start", at);
    repeat (3) @(negedge tb_ACLK);
    tb_ARESET = 1'b1;
    bus.host_req = 1'b0;
    #1;
    chk("ab_pulses", 40'({bus.host_ack, bus.poll_valid, bus.spi_start}), 40'd0);
    chk("ab_rdata", 40'({bus.host_status, bus.host_rdata}), 40'd0);
    chk("ab_spi_tx", bus.spi_tx, 40'd0);
    tx_q.delete();
    rsp_q.delete();
    exp_h.delete();
    repeat (3) @(negedge tb_ACLK);
    tb_ARESET = 1'b0;
    n0 = n_ack;
    s0 = st_h.size();
    repeat (20) @(negedge tb_ACLK);
    chk("ab_no_ack", 40'(n_ack), 40'(n0));
    chk("ab_no_start", 40'(st_h.size()), 40'(s0));
    tx_q.push_back(40'h24_0000_0000);
    tx_q.push_back(40'h24_0000_0000);
    rsp_q.push_back(40'h00_0000_0000);
    rsp_q.push_back(40'h0A_1234_5678);
    exp_h.push_back(mk_exp(FMASK, 40'h0A_1234_5678));
    bus.host_req = 1'b1;
    bus.host_addr = 7'h24;
    wait_ev(0, 80, "rd2_ack", a);
    bus.host_req = 1'b0;

    // tie after reset, alternation, periodic polls
    tb_ARESET = 1'b1;
    repeat (2) @(negedge tb_ACLK);
    tb_ARESET = 1'b0;
    @(negedge tb_ACLK);
    e = cyc;
    bus.poll_en = 1'b1;
    b = st_h.size();
    tx_q.push_back(40'hA2_AAAA_5555);
    tx_q.push_back(PTX);
    tx_q.push_back(PTX);
    tx_q.push_back(40'hA3_0000_0077);
    for (int i = 0; i < 6; i++) tx_q.push_back(PTX);
    rsp_q.push_back(40'h03_0000_0000);
    rsp_q.push_back(40'h00_0000_0000);
    rsp_q.push_back(40'h0F_CAFE_0001);
    rsp_q.push_back(40'h04_1111_2222);
    for (int i = 2; i <= 4; i++) begin
      rsp_q.push_back(40'h0);
      rsp_q.push_back({4'(i - 1), 4'hF, 16'hCAFE, 16'(i)});
      exp_p.push_back(mk_exp(FMASK, {4'(i - 1), 4'hF, 16'hCAFE, 16'(i)}));
    end
    exp_p.push_front(mk_exp(FMASK, 40'h0F_CAFE_0001));
    exp_h.push_back(mk_exp(SMASK, 40'h03_0000_0000));
    exp_h.push_back(mk_exp(SMASK, 40'h04_0000_0000));
    while (cyc < e + PER) @(negedge tb_ACLK);
    bus.host_req = 1'b1;
    bus.host_wr = 1'b1;
    bus.host_addr = 7'h22;
    bus.host_wdata = 32'hAAAA_5555;
    wait_ev(2, 20, "tie_start", at);
    chk("tie_host_first", 40'(at), 40'(e + PER + 1));
    wait_ev(0, 50, "w1_ack", a);
    bus.host_req = 1'b0;
    @(negedge tb_ACLK);
    bus.host_addr = 7'h23;
    bus.host_wdata = 32'h0000_0077;
    bus.host_req = 1'b1;
    wait_ev(1, 100, "p1_valid", at);
    wait_ev(0, 100, "w2_ack", a);
    bus.host_req = 1'b0;
    wait_ev(1, 200, "p2_valid", at);
    wait_ev(1, 200, "p3_valid", at);
    chk("poll_period",
        40'((st_h.size() > b + 6) ? st_h[b+6] - st_h[b+4] : -1),
        40'(PER));

    // drop poll_en mid-poll
    wait_ev(2, 200, "p4_start", at);
    repeat (3) @(negedge tb_ACLK);
    bus.poll_en = 1'b0;
    wait_ev(1, 100, "p4_valid", at);
    n0 = st_h.size();
    repeat (250) @(negedge tb_ACLK);
    chk("dis_no_start", 40'(st_h.size()), 40'(n0));
    chk("dis_tx_left", 40'(tx_q.size()), 40'd0);
    chk("poll_hold", 40'({bus.poll_status, bus.poll_data}), 40'h3F_CAFE_0004);
    chk("pv_count", 40'(n_pv), 40'd4);
    chk("exp_left", 40'(exp_h.size() + exp_p.size()), 40'd0);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
